// File: rtl/fwd_pkg.sv
// Shared constants and types for the forwarding / hazard unit.
package fwd_pkg;

  // Operand source selects driven onto the ALU input muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Interlock controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stallState_t;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwdSel(input logic exMemHit, input logic memWbHit);
    if (exMemHit) begin
      return FWD_MEM;
    end
    if (memWbHit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_sat_counter.sv
// Saturating event counter with synchronous clear.
module fwd_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear beats increment; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use interlock and performance counters
// for the five-stage MIPS pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_memread,
  input  logic              id_ex_regwrite,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  // Remaining stall cycles after the first (combinational) one.
  localparam logic [3:0] REM_INIT  = 4'(LOAD_LAT - 1);
  localparam logic       MULTI_LAT = (LOAD_LAT > 1);
  localparam logic       FWD_ON    = (FWD_EN != 0);

  stallState_t stateReg, stateNext;
  logic [3:0]  remReg, remNext;

  logic exMemHitA, exMemHitB, memWbHitA, memWbHitB;
  logic luHz, rawHz, hazard;

  // A writer matches a source when it writes, targets a real register and
  // the register numbers agree; r0 never participates.
  assign exMemHitA = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs);
  assign exMemHitB = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rt);
  assign memWbHitA = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs);
  assign memWbHitB = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt);

  assign forward_a = FWD_ON ? fwdSel(exMemHitA, memWbHitA) : FWD_RF;
  assign forward_b = FWD_ON ? fwdSel(exMemHitB, memWbHitB) : FWD_RF;

  assign luHz = id_ex_memread && (id_ex_rd != '0) &&
                ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));

  // Without forwarding, any in-flight writer of an ID source must be waited out.
  assign rawHz = (id_ex_regwrite  && (id_ex_rd  != '0) &&
                  ((id_ex_rd  == if_id_rs) || (id_ex_rd  == if_id_rt))) ||
                 (ex_mem_regwrite && (ex_mem_rd != '0) &&
                  ((ex_mem_rd == if_id_rs) || (ex_mem_rd == if_id_rt))) ||
                 (mem_wb_regwrite && (mem_wb_rd != '0) &&
                  ((mem_wb_rd == if_id_rs) || (mem_wb_rd == if_id_rt)));

  assign hazard = luHz || (!FWD_ON && rawHz);

  // Interlock state and remaining-cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      remReg   <= '0;
    end else begin
      stateReg <= stateNext;
      remReg   <= remNext;
    end
  end

  // Next-state and stall decode; hazard inputs are ignored while a bubble is in EX.
  always_comb begin
    stateNext = stateReg;
    remNext   = remReg;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        stall = hazard || mem_busy;
        if (luHz && MULTI_LAT) begin
          stateNext = STALL;
          remNext   = REM_INIT;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (!mem_busy) begin
          if (remReg <= 4'd1) begin
            stateNext = IDLE;
            remNext   = '0;
          end else begin
            remNext = remReg - 4'd1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        remNext   = '0;
      end
    endcase
  end

  fwd_sat_counter #(.CNT_W(CNT_W)) stallCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  fwd_sat_counter #(.CNT_W(CNT_W)) fwdCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   ((forward_a != FWD_RF) || (forward_b != FWD_RF)),
    .clr   (cnt_clr),
    .count (fwd_cnt)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: instance A forwards (LOAD_LAT=3, CNT_W=4),
// instance B has forwarding disabled (LOAD_LAT=1, CNT_W=16).
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_rd;
  logic       id_ex_memread, id_ex_regwrite;
  logic       ex_mem_regwrite, mem_wb_regwrite;
  logic [4:0] ex_mem_rd, mem_wb_rd;
  logic       mem_busy, cnt_clr;

  logic [1:0]  aFwdA, aFwdB, bFwdA, bFwdB;
  logic        aStall, bStall;
  logic [3:0]  aStallCnt, aFwdCnt;
  logic [15:0] bStallCnt, bFwdCnt;

  int compared = 0;
  int mismatched = 0;

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4), .FWD_EN(1)) dutA (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .forward_a(aFwdA), .forward_b(aFwdB), .stall(aStall),
    .stall_cnt(aStallCnt), .fwd_cnt(aFwdCnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16), .FWD_EN(0)) dutB (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .forward_a(bFwdA), .forward_b(bFwdB), .stall(bStall),
    .stall_cnt(bStallCnt), .fwd_cnt(bFwdCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) begin
      $display("ok   %-16s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic zeroInputs();
    if_id_rs = '0; if_id_rt = '0; id_ex_rs = '0; id_ex_rt = '0; id_ex_rd = '0;
    id_ex_memread = 1'b0; id_ex_regwrite = 1'b0;
    ex_mem_regwrite = 1'b0; ex_mem_rd = '0;
    mem_wb_regwrite = 1'b0; mem_wb_rd = '0;
    mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // Inputs change on the falling edge, away from the active edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clearCounters();
    cyc(); zeroInputs(); cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0;
  endtask

  // One load-use hazard cycle followed by bubbles; busy window on cycles 1..2 if requested.
  task automatic runLoad(input logic busy, output int highsA, output int highsB);
    highsA = 0; highsB = 0;
    cyc(); zeroInputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd8; if_id_rt = 5'd8;
    #1;
    highsA += int'(aStall); highsB += int'(bStall);
    for (int i = 1; i < 8; i++) begin
      cyc(); zeroInputs();
      mem_busy = busy && (i == 1 || i == 2);
      #1;
      highsA += int'(aStall); highsB += int'(bStall);
    end
    cyc(); zeroInputs();
  endtask

  int hA, hB;

  initial begin
    zeroInputs();
    rst = 1'b1;

    // Reset state
    cyc(); #1;
    chk("rst_fwdA", aFwdA, 2'b00);
    chk("rst_fwdB", aFwdB, 2'b00);
    chk("rst_stallA", aStall, 1'b0);
    chk("rst_stallcntA", aStallCnt, 0);
    chk("rst_fwdcntA", aFwdCnt, 0);
    chk("rst_stallB", bStall, 1'b0);
    rst = 1'b0;

    // EX/MEM beats MEM/WB on rs; rt untouched
    cyc();
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs = 5'd5;
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd5;
    #1;
    chk("prio_fwdA", aFwdA, 2'b10);
    chk("prio_fwdB", aFwdB, 2'b00);
    chk("nofwd_fwdA_B", bFwdA, 2'b00);
    cyc(); zeroInputs(); #1;
    chk("fwdcnt_plus1", aFwdCnt, 1);
    chk("nofwd_fwdcnt_B", bFwdCnt, 0);

    // r0 never forwarded
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd0; id_ex_rt = 5'd0;
    #1;
    chk("r0_fwdB", aFwdB, 2'b00);
    // MEM/WB on rt
    cyc(); mem_wb_rd = 5'd7; id_ex_rt = 5'd7; #1;
    chk("wb_fwdB", aFwdB, 2'b01);
    chk("wb_fwdA", aFwdA, 2'b00);
    // EX/MEM priority on rt
    cyc(); ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd7; #1;
    chk("mem_fwdB", aFwdB, 2'b10);
    cyc(); zeroInputs(); #1;
    chk("fwdcnt_3", aFwdCnt, 3);

    // Load-use, LOAD_LAT=3 on A and 1 on B
    clearCounters(); #1;
    chk("clr_fwdcnt", aFwdCnt, 0);
    runLoad(1'b0, hA, hB);
    #1;
    chk("lu_highsA", hA, 3);
    chk("lu_highsB", hB, 1);
    chk("lu_stallcntA", aStallCnt, 3);
    chk("lu_stallcntB", bStallCnt, 1);

    // Load-use with mem_busy for 2 cycles while stalled
    clearCounters();
    runLoad(1'b1, hA, hB);
    #1;
    chk("busy_highsA", hA, 5);
    chk("busy_highsB", hB, 3);
    chk("busy_stallcntA", aStallCnt, 5);

    // Reset on the 2nd stall cycle
    cyc(); zeroInputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd8; if_id_rt = 5'd8;
    #1; chk("mid_stall1", aStall, 1'b1);
    cyc(); zeroInputs(); #1;
    chk("mid_stall2", aStall, 1'b1);
    rst = 1'b1; #1;
    chk("mid_rst_stall", aStall, 1'b0);
    chk("mid_rst_stallcnt", aStallCnt, 0);
    chk("mid_rst_fwdcnt", aFwdCnt, 0);
    cyc(); rst = 1'b0;
    runLoad(1'b0, hA, hB);
    #1;
    chk("restart_highsA", hA, 3);
    chk("restart_stallcnt", aStallCnt, 3);

    // Saturation of a 4-bit counter, then clear while still forwarding
    clearCounters();
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs = 5'd5;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    chk("sat_fwdcnt", aFwdCnt, 15);
    chk("sat_fwdcnt_B", bFwdCnt, 0);
    cnt_clr = 1'b1;
    cyc(); #1;
    chk("satclr_fwdcnt", aFwdCnt, 0);
    cnt_clr = 1'b0;
    cyc(); #1;
    chk("after_clr_fwdcnt", aFwdCnt, 1);

    // RAW stalls only when forwarding is disabled
    cyc(); zeroInputs();
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd9; if_id_rs = 5'd9;
    #1;
    chk("raw_exmem_B", bStall, 1'b1);
    chk("raw_exmem_A", aStall, 1'b0);
    cyc(); zeroInputs();
    id_ex_regwrite = 1'b1; id_ex_rd = 5'd4; if_id_rt = 5'd4;
    #1;
    chk("raw_ex_B", bStall, 1'b1);
    chk("raw_ex_A", aStall, 1'b0);
    cyc(); zeroInputs();
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd0; if_id_rs = 5'd0;
    #1;
    chk("raw_r0_B", bStall, 1'b0);
    cyc(); zeroInputs();
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd12; if_id_rt = 5'd12;
    #1;
    chk("raw_wb_B", bStall, 1'b1);
    cyc(); zeroInputs(); #1;
    chk("raw_gone_B", bStall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
